vend_change_sequencer: RTL
==========================

Name: vend_change_sequencer

Overview:
Sequences the coin hoppers that return change after a vend. The vending machine core hands over a change amount in cents. The block dispenses it greedily, largest denomination first, one coin at a time over a four-phase req/ack handshake with the hopper mechanism. It sits between the vending FSM's give-change step and the physical coin hoppers, and it skips hoppers that report empty.

Parameters:
DENOM0, 100, value in cents of hopper 0 (largest)
DENOM1, 25, value of hopper 1
DENOM2, 10, value of hopper 2
DENOM3, 5, value of hopper 3 (smallest); DENOM0>DENOM1>DENOM2>DENOM3>0 required
AMT_W, 16, width of the change amount
TIMEOUT_CYC, 1023, ack watchdog limit in cycles (optional feature only)

Ports:
I_CLK  in  1  clock; all logic on rising edge
I_RESET_N  in  1  asynchronous, active-low reset
I_START  in  1  single-cycle pulse; latch I_AMOUNT, begin dispensing
I_AMOUNT  in  AMT_W  change owed, in cents
I_EMPTY  in  4  per-hopper empty flag, bit n = hopper n
I_COIN_ACK  in  1  hopper ack (four-phase)
I_ERR_CLR  in  1  clears the ERROR state
O_COIN_REQ  out  1  request one coin from hopper O_COIN_SEL
O_COIN_SEL  out  2  hopper index; stable while O_COIN_REQ is high
O_BUSY  out  1  high in every state except IDLE and ERROR
O_DONE  out  1  one-cycle pulse when the remainder reaches 0
O_ERROR  out  1  high while in ERROR
O_REMAIN  out  AMT_W  cents still owed
O_COIN_CNT  out  8  coins dispensed for the current transaction; saturates at 255

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, including O_REMAIN, O_COIN_CNT and O_COIN_SEL.
- States: IDLE, SELECT, REQ, RELEASE, DONE, ERROR.
- IDLE:
  - I_START=1 → latch I_AMOUNT into the remainder, clear O_COIN_CNT, go to SELECT.
  - I_START is ignored in every other state.
- SELECT (one cycle):
  - remainder==0 → DONE.
  - Otherwise pick the lowest index n with DENOMn<=remainder and I_EMPTY[n]==0. Set O_COIN_SEL=n and go to REQ.
  - No such n → ERROR. The remainder is held and stays visible on O_REMAIN.
- REQ:
  - O_COIN_REQ=1, held until I_COIN_ACK is sampled 1.
  - On ack: subtract DENOMn from the remainder, increment O_COIN_CNT, drop REQ, go to RELEASE.
  - I_EMPTY changes during REQ do not abort the handshake in progress.
- RELEASE: wait for I_COIN_ACK==0, then go to SELECT. Minimum coin period is 3 cycles (SELECT, REQ, RELEASE) with zero-latency ack.
- DONE: O_DONE=1 for exactly one cycle, then IDLE. O_REMAIN=0 and O_COIN_CNT keeps its final value.
- ERROR: O_ERROR=1. I_ERR_CLR=1 → IDLE with the remainder cleared to 0.
- I_START=1 with I_AMOUNT=0: IDLE→SELECT→DONE, so O_DONE pulses on the 2nd cycle after start and no coin is requested.
- Subtraction cannot underflow, because a denomination is only chosen if it is <= the remainder. AMT_W-bit unsigned arithmetic throughout.
- An ack already high on entry to REQ counts as the ack for that coin.
- Reset mid-handshake drops O_COIN_REQ immediately. The partial transaction is lost; the vending FSM re-issues it.

Optional Feature:
- Macro: VEND_CHANGE_TIMEOUT_EN.
- Defined:
  - A 10-bit counter runs in REQ and in RELEASE.
  - If it reaches TIMEOUT_CYC without the awaited ack edge, the block goes to ERROR and O_COIN_REQ drops.
  - The coin is not subtracted.
  - The counter clears on every state change.
- Undefined: no counter; the block waits in REQ/RELEASE indefinitely.

Decomposition:
- Shared package vend_pkg holds:
  - the state encoding typedef for this FSM;
  - the default denomination constants (shared with the vending machine's price logic);
  - the hopper index width (2).
- One natural sub-module, vend_coin_pick: combinational priority select of the first hopper that fits and is not empty. Inputs are the remainder, I_EMPTY and the denominations; outputs are an index and a valid flag.

Test Plan:
- Amount 65, no hoppers empty, ack 1 cycle after req → coins 25,25,10,5 on O_COIN_SEL 1,1,2,3; O_DONE pulses once; O_COIN_CNT=4; O_REMAIN=0.
- Amount 140 → coins 100,25,10,5 (sel 0,1,2,3); O_COIN_CNT=4.
- Amount 30, I_EMPTY=4'b0010 (quarters empty) → 10,10,10; O_COIN_CNT=3; O_DONE pulses.
- Amount 13 → 10 then 3 remaining → O_ERROR=1, O_REMAIN=3; I_ERR_CLR → IDLE, O_REMAIN=0.
- Amount 0 → O_DONE on the 2nd cycle after I_START; O_COIN_REQ never asserts. A second I_START while busy on amount 40 is ignored.
- I_RESET_N low while O_COIN_REQ=1 → O_COIN_REQ=0 in the same cycle, all outputs 0. With VEND_CHANGE_TIMEOUT_EN and TIMEOUT_CYC=16, withholding ack → ERROR after 16 cycles, remainder unchanged.

Source files
------------

// File: rtl/vend_change_sequencer_pkg.sv
// Shared vending definitions: change-sequencer state encoding, default coin
// denominations (also used by the price logic) and the hopper index width.
package vend_pkg;

  localparam int DENOM0_DEF   = 100;
  localparam int DENOM1_DEF   = 25;
  localparam int DENOM2_DEF   = 10;
  localparam int DENOM3_DEF   = 5;

  localparam int HOPPER_IDX_W = 2;
  localparam int TIMER_W      = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_REQ,
    ST_RELEASE,
    ST_DONE,
    ST_ERROR
  } vend_state_t;

endpackage

// File: rtl/vend_change_sequencer_if.sv
// Bundle between the vending core / coin hoppers and the change sequencer.
// The master side drives the I_* signals; the sequencer (slave) drives O_*.
interface vend_change_sequencer_if
  import vend_pkg::*;
#(
  parameter int AMT_W = 16
);

  logic                    I_START;
  logic [AMT_W-1:0]        I_AMOUNT;
  logic [3:0]              I_EMPTY;
  logic                    I_COIN_ACK;
  logic                    I_ERR_CLR;
  logic                    O_COIN_REQ;
  logic [HOPPER_IDX_W-1:0] O_COIN_SEL;
  logic                    O_BUSY;
  logic                    O_DONE;
  logic                    O_ERROR;
  logic [AMT_W-1:0]        O_REMAIN;
  logic [7:0]              O_COIN_CNT;

  modport master (
    output I_START, I_AMOUNT, I_EMPTY, I_COIN_ACK, I_ERR_CLR,
    input  O_COIN_REQ, O_COIN_SEL, O_BUSY, O_DONE, O_ERROR, O_REMAIN, O_COIN_CNT
  );

  modport slave (
    input  I_START, I_AMOUNT, I_EMPTY, I_COIN_ACK, I_ERR_CLR,
    output O_COIN_REQ, O_COIN_SEL, O_BUSY, O_DONE, O_ERROR, O_REMAIN, O_COIN_CNT
  );

endinterface

// File: rtl/vend_change_sequencer_coin_pick.sv
// Greedy hopper choice: the largest denomination (lowest index) that still
// fits in the remainder and whose hopper is not reporting empty.
module vend_coin_pick
  import vend_pkg::*;
#(
  parameter int AMT_W = 16
) (
  input  logic [AMT_W-1:0]        remain,
  input  logic [3:0]              empty,
  input  logic [AMT_W-1:0]        denom0,
  input  logic [AMT_W-1:0]        denom1,
  input  logic [AMT_W-1:0]        denom2,
  input  logic [AMT_W-1:0]        denom3,
  output logic [HOPPER_IDX_W-1:0] idx,
  output logic                    valid
);

  // Priority chain from the largest coin down; no match leaves valid low.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    if (!empty[0] && (denom0 <= remain)) begin
      idx   = 2'd0;
      valid = 1'b1;
    end else if (!empty[1] && (denom1 <= remain)) begin
      idx   = 2'd1;
      valid = 1'b1;
    end else if (!empty[2] && (denom2 <= remain)) begin
      idx   = 2'd2;
      valid = 1'b1;
    end else if (!empty[3] && (denom3 <= remain)) begin
      idx   = 2'd3;
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/vend_change_sequencer.sv
// Change-return sequencer: dispenses a latched amount greedily, one coin per
// four-phase req/ack handshake with the hoppers, skipping empty hoppers.
// Optional ack watchdog: define VEND_CHANGE_TIMEOUT_EN to send a stalled
// handshake (no ack edge within TIMEOUT_CYC cycles) to ERROR.
module vend_change_sequencer
  import vend_pkg::*;
#(
  parameter int DENOM0      = DENOM0_DEF,
  parameter int DENOM1      = DENOM1_DEF,
  parameter int DENOM2      = DENOM2_DEF,
  parameter int DENOM3      = DENOM3_DEF,
  parameter int AMT_W       = 16,
  parameter int TIMEOUT_CYC = 1023
) (
  input logic                     I_CLK,
  input logic                     I_RESET_N,
  vend_change_sequencer_if.slave  bus
);

  localparam logic [AMT_W-1:0] D0 = AMT_W'(DENOM0);
  localparam logic [AMT_W-1:0] D1 = AMT_W'(DENOM1);
  localparam logic [AMT_W-1:0] D2 = AMT_W'(DENOM2);
  localparam logic [AMT_W-1:0] D3 = AMT_W'(DENOM3);

  vend_state_t             state;
  logic [AMT_W-1:0]        remain;
  logic [7:0]              coin_cnt;
  logic [HOPPER_IDX_W-1:0] coin_sel;
  logic                    coin_req;
  logic                    busy;
  logic                    done;
  logic                    error;
  logic [HOPPER_IDX_W-1:0] pick_idx;
  logic                    pick_valid;
  logic [AMT_W-1:0]        sel_denom;

`ifdef VEND_CHANGE_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] TIMER_LIM = TIMER_W'(TIMEOUT_CYC - 1);
  logic [TIMER_W-1:0] timer;
`endif

  vend_coin_pick #(.AMT_W(AMT_W)) u_pick (
    .remain (remain),
    .empty  (bus.I_EMPTY),
    .denom0 (D0),
    .denom1 (D1),
    .denom2 (D2),
    .denom3 (D3),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // Value of the coin currently being handed out, subtracted on its ack.
  always_comb begin
    sel_denom = D0;
    case (coin_sel)
      2'd0:    sel_denom = D0;
      2'd1:    sel_denom = D1;
      2'd2:    sel_denom = D2;
      default: sel_denom = D3;
    endcase
  end

  // Dispense FSM; all outputs are registered alongside the state.
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state    <= ST_IDLE;
      remain   <= '0;
      coin_cnt <= '0;
      coin_sel <= '0;
      coin_req <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
`ifdef VEND_CHANGE_TIMEOUT_EN
      timer    <= '0;
`endif
    end else begin
`ifdef VEND_CHANGE_TIMEOUT_EN
      timer <= '0;
`endif
      unique case (state)
        ST_IDLE: begin
          if (bus.I_START) begin
            remain   <= bus.I_AMOUNT;
            coin_cnt <= '0;
            busy     <= 1'b1;
            state    <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (remain == '0) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (pick_valid) begin
            coin_sel <= pick_idx;
            coin_req <= 1'b1;
            state    <= ST_REQ;
          end else begin
            busy  <= 1'b0;
            error <= 1'b1;
            state <= ST_ERROR;
          end
        end
        ST_REQ: begin
          if (bus.I_COIN_ACK) begin
            remain   <= remain - sel_denom;
            if (coin_cnt != 8'hFF) begin
              coin_cnt <= coin_cnt + 8'd1;
            end
            coin_req <= 1'b0;
            state    <= ST_RELEASE;
          end
`ifdef VEND_CHANGE_TIMEOUT_EN
          else if (timer == TIMER_LIM) begin
            coin_req <= 1'b0;
            busy     <= 1'b0;
            error    <= 1'b1;
            state    <= ST_ERROR;
          end else begin
            timer <= timer + 1'b1;
          end
`endif
        end
        ST_RELEASE: begin
          if (!bus.I_COIN_ACK) begin
            state <= ST_SELECT;
          end
`ifdef VEND_CHANGE_TIMEOUT_EN
          else if (timer == TIMER_LIM) begin
            busy  <= 1'b0;
            error <= 1'b1;
            state <= ST_ERROR;
          end else begin
            timer <= timer + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        ST_ERROR: begin
          if (bus.I_ERR_CLR) begin
            error  <= 1'b0;
            remain <= '0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.O_COIN_REQ = coin_req;
  assign bus.O_COIN_SEL = coin_sel;
  assign bus.O_BUSY     = busy;
  assign bus.O_DONE     = done;
  assign bus.O_ERROR    = error;
  assign bus.O_REMAIN   = remain;
  assign bus.O_COIN_CNT = coin_cnt;

endmodule
